debug_log_uart_dump: RTL and testbench

DEBUG_LOG_UART_DUMP -- requirements
Module: debug_log_uart_dump

---
 rtl/debug_log_uart_dump.sv | 189 ++++++++++++++++++
 tb/tb_debug_log_uart_dump.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_log_uart_dump.sv
// Dumps a snapshot of a packed debug log as uppercase hex text over a UART 8N1 line.
// Each entry is sent as hex digits plus a space; the dump ends with CR LF.
module debug_log_uart_dump #(
  parameter int W            = 5,
  parameter int DEPTH        = 32,
  parameter int ADDR_W       = $clog2(DEPTH),
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 dump_req,
  input  logic [W*DEPTH-1:0]   mem_flat,
  input  logic [ADDR_W:0]      count,
  output logic                 uart_tx,
  output logic                 busy,
  output logic                 done
);

  localparam int HEX_DIGITS = (W + 3) / 4;
  localparam int DIG_W      = (HEX_DIGITS > 1) ? $clog2(HEX_DIGITS) : 1;
  localparam int BAUD_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(HEX_DIGITS - 1);
  localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, DIGIT, SEP, CR, LF} ctrl_t;
  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_t;

  ctrl_t                ctrl;
  bit_t                 phase;
  logic                 req_q;
  logic [W*DEPTH-1:0]   snap_mem;
  logic [ADDR_W:0]      snap_cnt;
  logic [ADDR_W:0]      entry;
  logic [DIG_W-1:0]     digit;
  logic [BAUD_W-1:0]    baud;
  logic [2:0]           bitn;
  logic [7:0]           shreg;

  ctrl_t                nxt_ctrl;
  logic [ADDR_W:0]      nxt_entry;
  logic [DIG_W-1:0]     nxt_digit;
  ctrl_t                sel_ctrl;
  logic [ADDR_W:0]      sel_entry;
  logic [DIG_W-1:0]     sel_digit;
  logic [4*HEX_DIGITS-1:0] ext;
  logic [4*HEX_DIGITS-1:0] shifted;
  logic [3:0]           nib;
  logic [7:0]           tx_char;
  logic [ADDR_W:0]      cnt_clamp;
  logic                 req_edge;

  assign req_edge  = dump_req & ~req_q;
  assign cnt_clamp = (count > DEPTH_C) ? DEPTH_C : count;

  // ctrl names the character currently on the line; nxt_* is the one after it
  always_comb begin
    nxt_ctrl  = ctrl;
    nxt_entry = entry;
    nxt_digit = digit;
    case (ctrl)
      DIGIT: begin
        if (digit == DIG_LAST) begin
          nxt_ctrl  = SEP;
          nxt_digit = '0;
        end else begin
          nxt_digit = digit + 1'b1;
        end
      end
      SEP: begin
        if (entry + 1'b1 == snap_cnt) begin
          nxt_ctrl = CR;
        end else begin
          nxt_ctrl  = DIGIT;
          nxt_entry = entry + 1'b1;
        end
      end
      CR:      nxt_ctrl = LF;
      default: nxt_ctrl = ctrl;
    endcase
  end

  // The first character of a dump loads from the current state; later ones
  // load from the successor state at the end of the previous stop bit.
  always_comb begin
    sel_ctrl  = (phase == B_IDLE) ? ctrl  : nxt_ctrl;
    sel_entry = (phase == B_IDLE) ? entry : nxt_entry;
    sel_digit = (phase == B_IDLE) ? digit : nxt_digit;
    ext       = '0;
    ext[W-1:0] = snap_mem[W*int'(sel_entry) +: W];
    shifted   = ext >> (4 * (DIG_LAST - sel_digit));
    nib       = shifted[3:0];
    case (sel_ctrl)
      DIGIT:   tx_char = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
      SEP:     tx_char = 8'h20;
      CR:      tx_char = 8'h0D;
      LF:      tx_char = 8'h0A;
      default: tx_char = '1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ctrl     <= IDLE;
      phase    <= B_IDLE;
      req_q    <= 1'b0;
      snap_mem <= '0;
      snap_cnt <= '0;
      entry    <= '0;
      digit    <= '0;
      baud     <= '0;
      bitn     <= '0;
      shreg    <= '0;
      uart_tx  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      req_q <= dump_req;
      done  <= 1'b0;
      case (phase)
        B_IDLE: begin
          if (ctrl == IDLE) begin
            if (req_edge && !done) begin
              snap_mem <= mem_flat;
              snap_cnt <= cnt_clamp;
              entry    <= '0;
              digit    <= '0;
              busy     <= 1'b1;
              ctrl     <= (cnt_clamp == '0) ? CR : DIGIT;
            end
          end else begin
            uart_tx <= 1'b0;
            shreg   <= tx_char;
            baud    <= '0;
            phase   <= B_START;
          end
        end
        B_START: begin
          if (baud == BAUD_LAST) begin
            baud    <= '0;
            bitn    <= '0;
            uart_tx <= shreg[0];
            shreg   <= shreg >> 1;
            phase   <= B_DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        B_DATA: begin
          if (baud == BAUD_LAST) begin
            baud <= '0;
            if (bitn == 3'd7) begin
              uart_tx <= 1'b1;
              phase   <= B_STOP;
            end else begin
              bitn    <= bitn + 1'b1;
              uart_tx <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          if (baud == BAUD_LAST) begin
            baud <= '0;
            if (ctrl == LF) begin
              phase <= B_IDLE;
              ctrl  <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              ctrl    <= nxt_ctrl;
              entry   <= nxt_entry;
              digit   <= nxt_digit;
              shreg   <= tx_char;
              uart_tx <= 1'b0;
              phase   <= B_START;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_log_uart_dump.sv
// Bench for debug_log_uart_dump: per-cycle line/busy/done model plus a UART receiver
// checked against hand-computed byte streams.
module tb_debug_log_uart_dump;
  localparam int W = 5, DEPTH = 32, AW = 5, CPB = 4, HD = 2;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic                 dump_req;
  logic [W*DEPTH-1:0]   mem_flat;
  logic [AW:0]          count;
  logic                 uart_tx, busy, done;

  always #5 clk = ~clk;

  debug_log_uart_dump #(.W(W), .DEPTH(DEPTH), .ADDR_W(AW), .CLKS_PER_BIT(CPB)) u_dut (
    .clk(clk), .rstn(rstn), .dump_req(dump_req), .mem_flat(mem_flat),
    .count(count), .uart_tx(uart_tx), .busy(busy), .done(done)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: on an accepted request, expand the snapshot into text, then into line levels per cycle.
  bit         m_prev = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_tx = 1'b1;
  bit         m_edge, m_start;
  int         m_left = 0;
  bit         lvl_q[$];
  logic [7:0] m_bytes[$];

  function automatic void build(input logic [W*DEPTH-1:0] mem, input int cnt);
    int c, v, nb;
    logic [7:0] ch;
    m_bytes.delete();
    lvl_q.delete();
    c = (cnt > DEPTH) ? DEPTH : cnt;
    for (int i = 0; i < c; i++) begin
      v = int'(mem[W*i +: W]);
      for (int d = HD - 1; d >= 0; d--) begin
        nb = (v >> (4 * d)) & 15;
        m_bytes.push_back((nb < 10) ? 8'(48 + nb) : 8'(65 + nb - 10));
      end
      m_bytes.push_back(8'h20);
    end
    m_bytes.push_back(8'h0D);
    m_bytes.push_back(8'h0A);
    foreach (m_bytes[k]) begin
      ch = m_bytes[k];
      for (int t = 0; t < CPB; t++) lvl_q.push_back(1'b0);
      for (int b = 0; b < 8; b++)
        for (int t = 0; t < CPB; t++) lvl_q.push_back(ch[b]);
      for (int t = 0; t < CPB; t++) lvl_q.push_back(1'b1);
    end
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_prev = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_tx = 1'b1; m_left = 0;
      lvl_q.delete();
    end else begin
      m_edge  = dump_req && !m_prev;
      m_prev  = dump_req;
      m_start = m_edge && !m_busy && !m_done;
      m_done  = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0; m_done = 1'b1; m_tx = 1'b1;
        end else begin
          m_tx = lvl_q.pop_front();
        end
      end else if (m_start) begin
        build(mem_flat, int'(count));
        m_busy = 1'b1;
        m_tx   = 1'b1;
        m_left = 1 + lvl_q.size();
      end
    end
  end

  bit cmp_en = 1'b0;
  int busy_cyc = 0, done_cnt = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("line", uart_tx, m_tx);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      if (busy) busy_cyc++;
      if (done) done_cnt++;
    end
  end

  // UART receiver sampling mid-bit on the falling clock edge
  logic [7:0] rx_q[$];
  logic [7:0] rx_byte;
  bit         rx_active = 1'b0;
  int         rx_cnt = 0;

  always @(negedge clk) begin
    if (!rstn) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (uart_tx == 1'b0) begin
        rx_active = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % CPB == 0 && rx_cnt / CPB >= 1 && rx_cnt / CPB <= 8)
        rx_byte[rx_cnt / CPB - 1] = uart_tx;
      if (rx_cnt == 9 * CPB) begin
        chk("rx_stop", uart_tx, 1'b1);
        rx_q.push_back(rx_byte);
        rx_active = 1'b0;
      end
    end
  end

  logic [7:0] lit_q[$];

  task automatic chk_stream(input string nm);
    chk({nm, "_len"}, rx_q.size(), lit_q.size());
    for (int i = 0; i < rx_q.size() && i < lit_q.size(); i++)
      chk($sformatf("%s[%0d]", nm, i), rx_q[i], lit_q[i]);
  endtask

  task automatic chk_model(input string nm);
    chk({nm, "_mlen"}, rx_q.size(), m_bytes.size());
    for (int i = 0; i < rx_q.size() && i < m_bytes.size(); i++)
      chk($sformatf("%s_m[%0d]", nm, i), rx_q[i], m_bytes[i]);
  endtask

  task automatic clear_stats();
    rx_q.delete();
    busy_cyc = 0;
    done_cnt = 0;
  endtask

  task automatic pulse();
    @(negedge clk) dump_req = 1'b1;
    @(negedge clk) dump_req = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) chk({nm, "_timeout"}, done, 1'b1);
  endtask

  task automatic set_three();
    mem_flat = '1;
    mem_flat[4:0]   = 5'h00;
    mem_flat[9:5]   = 5'h1F;
    mem_flat[14:10] = 5'h0A;
    count = 6'd3;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; dump_req = 1'b0; mem_flat = '0; count = '0;
    repeat (3) @(negedge clk);
    chk("reset_line", uart_tx, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    cmp_en = 1'b1;
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // empty log
    clear_stats();
    count = 6'd0;
    pulse();
    wait_done("empty", 200);
    repeat (3) @(negedge clk);
    lit_q = '{8'h0D, 8'h0A};
    chk_stream("empty");
    chk_model("empty");
    chk("empty_busy_cycles", busy_cyc, 81);
    chk("empty_done_pulses", done_cnt, 1);

    // three entries
    clear_stats();
    set_three();
    pulse();
    wait_done("three", 1000);
    repeat (3) @(negedge clk);
    lit_q = '{8'h30, 8'h30, 8'h20, 8'h31, 8'h46, 8'h20, 8'h30, 8'h41, 8'h20, 8'h0D, 8'h0A};
    chk_stream("three");
    chk_model("three");
    chk("three_busy_cycles", busy_cyc, 441);

    // full log, count over DEPTH, inputs scrambled every cycle after the snapshot
    clear_stats();
    for (int i = 0; i < DEPTH; i++) mem_flat[W*i +: W] = 5'(i);
    count = 6'd40;
    @(negedge clk) dump_req = 1'b1;
    @(negedge clk) dump_req = 1'b0;
    for (int n = 0; n < 5000 && done !== 1'b1; n++) begin
      mem_flat = {5{$urandom()}};
      count = 6'($urandom_range(0, 63));
      @(negedge clk);
    end
    if (done !== 1'b1) chk("full_timeout", done, 1'b1);
    repeat (3) @(negedge clk);
    chk("full_len", rx_q.size(), 98);
    if (rx_q.size() == 98) begin
      chk("full_b0", rx_q[0], 8'h30);
      chk("full_b1", rx_q[1], 8'h30);
      chk("full_b93", rx_q[93], 8'h31);
      chk("full_b94", rx_q[94], 8'h46);
      chk("full_b96", rx_q[96], 8'h0D);
      chk("full_b97", rx_q[97], 8'h0A);
    end
    chk_model("full");
    chk("full_busy_cycles", busy_cyc, 3921);

    // held request with an extra pulse while busy
    clear_stats();
    set_three();
    @(negedge clk) dump_req = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      if (n == 100) dump_req = 1'b0;
      if (n == 101) dump_req = 1'b1;
    end
    dump_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("hold_done_pulses", done_cnt, 1);
    chk("hold_busy_cycles", busy_cyc, 441);

    // edge during the done cycle is dropped
    clear_stats();
    pulse();
    wait_done("done_edge", 1000);
    dump_req = 1'b1;
    @(negedge clk);
    chk("done_edge_ignored", busy, 1'b0);
    repeat (3) @(negedge clk);
    dump_req = 1'b0;
    chk("done_edge_pulses", done_cnt, 1);

    // edge one cycle after done starts a new dump
    clear_stats();
    pulse();
    wait_done("after_done_a", 1000);
    @(negedge clk) dump_req = 1'b1;
    @(negedge clk);
    chk("after_done_start", busy, 1'b1);
    dump_req = 1'b0;
    wait_done("after_done_b", 1000);
    repeat (2) @(negedge clk);
    chk("after_done_pulses", done_cnt, 2);

    // reset in data bit 3 of the first character, request held through release
    clear_stats();
    pulse();
    repeat (17) @(negedge clk);
    chk("pre_reset_line", uart_tx, 1'b0);
    #2;
    rstn = 1'b0;
    dump_req = 1'b1;
    #1;
    chk("async_line", uart_tx, 1'b1);
    chk("async_busy", busy, 1'b0);
    chk("async_done", done, 1'b0);
    @(negedge clk);
    clear_stats();
    #2 rstn = 1'b1;
    @(negedge clk);
    chk("release_start", busy, 1'b1);
    wait_done("post_reset", 1000);
    dump_req = 1'b0;
    repeat (3) @(negedge clk);
    lit_q = '{8'h30, 8'h30, 8'h20, 8'h31, 8'h46, 8'h20, 8'h30, 8'h41, 8'h20, 8'h0D, 8'h0A};
    chk_stream("post_reset");
    chk("post_reset_busy_cycles", busy_cyc, 441);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
